mem_access_stage: RTL

//  Pipeline stage directly downstream of EX. Registers EX outputs, performs the data-memory load/store via a req/ack handshake and aligns byte lanes.

---
 rtl/mem_access_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage sitting directly after EX.
// Registers the EX slot, runs one data-memory access per slot over a
// req/ack handshake, steers store byte lanes and extracts/extends load data.
// PIPELINE_VALID stays low while an access is outstanding.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned H/W accesses
// (no memory request, align_err raised, register write suppressed).

`ifndef REG_WRITE_BUS_LENGTH
`define REG_WRITE_BUS_LENGTH 6
`endif
`ifndef MEM_CONTRAL_BUS_LENGTH
`define MEM_CONTRAL_BUS_LENGTH 5
`endif
`ifndef EX_RESULT_BUS_LENGTH
`define EX_RESULT_BUS_LENGTH 64
`endif

module mem_access_stage #(
  parameter int DMEM_AW = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               PIPELINE_FLUSH,
  input  logic                               PIPELINE_READY,
  output logic                               PIPELINE_VALID,
  input  logic [`REG_WRITE_BUS_LENGTH-1:0]   s_reg_write_bus_i,
  input  logic [`MEM_CONTRAL_BUS_LENGTH-1:0] s_mem_contral_bus_i,
  input  logic [`EX_RESULT_BUS_LENGTH-1:0]   ex_result_bus_i,
  output logic                               dmem_req,
  output logic                               dmem_we,
  output logic [DMEM_AW-1:0]                 dmem_addr,
  output logic [3:0]                         dmem_wstrb,
  output logic [31:0]                        dmem_wdata,
  input  logic                               dmem_ack,
  input  logic [31:0]                        dmem_rdata,
  output logic [`REG_WRITE_BUS_LENGTH-1:0]   s_reg_write_bus,
  output logic [31:0]                        mem_result,
  output logic                               align_err
);

  // Mem control field layout: {MEM_READ, MEM_WRITE, MEM_SIZE[1:0], MEM_UNSIGNED}
  localparam int MC_READ  = 4;
  localparam int MC_WRITE = 3;
  localparam int MC_SIZE  = 1;
  localparam int MC_UNS   = 0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic        capture, mem_op_in, mis_in, bubble_in;
  logic [31:0] ea_in, rt_in;
  logic        mem_read, mem_write, mem_unsigned, align_q;
  logic [1:0]  mem_size;
  logic [31:0] ea, rt, load_q, load_ext;
  logic [`REG_WRITE_BUS_LENGTH-1:0] wb_q;

  assign ea_in = ex_result_bus_i[`EX_RESULT_BUS_LENGTH-1 -: 32];
  assign rt_in = ex_result_bus_i[31:0];

  // READY while busy is ignored: capture only when the slot is finished.
  assign PIPELINE_VALID = (state != BUSY);
  assign capture        = PIPELINE_READY & PIPELINE_VALID;
  assign mem_op_in      = ~PIPELINE_FLUSH &
                          (s_mem_contral_bus_i[MC_READ] | s_mem_contral_bus_i[MC_WRITE]);

`ifdef MEM_ALIGN_CHECK_EN
  // Halfword needs ea[0]==0, word (size 1x) needs ea[1:0]==0.
  assign mis_in = mem_op_in &
    ((s_mem_contral_bus_i[MC_SIZE +: 2] == 2'b01 & ea_in[0]) |
     (s_mem_contral_bus_i[MC_SIZE + 1] & (|ea_in[1:0])));
`else
  assign mis_in = 1'b0;
`endif

  // A flushed or trapped slot carries no register write and no memory op.
  assign bubble_in = PIPELINE_FLUSH | mis_in;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one access per captured mem op; trapped slots skip straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (capture) state_nxt = mis_in ? DONE : (mem_op_in ? BUSY : IDLE);
      BUSY:       if (dmem_ack) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Slot capture of write bus, mem control and EX data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q         <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_size     <= 2'b00;
      mem_unsigned <= 1'b0;
      ea           <= '0;
      rt           <= '0;
      align_q      <= 1'b0;
    end else if (capture) begin
      ea      <= ea_in;
      rt      <= rt_in;
      align_q <= mis_in;
      if (bubble_in) begin
        wb_q         <= '0;
        mem_read     <= 1'b0;
        mem_write    <= 1'b0;
        mem_size     <= 2'b00;
        mem_unsigned <= 1'b0;
      end else begin
        wb_q         <= s_reg_write_bus_i;
        mem_read     <= s_mem_contral_bus_i[MC_READ];
        mem_write    <= s_mem_contral_bus_i[MC_WRITE];
        mem_size     <= s_mem_contral_bus_i[MC_SIZE +: 2];
        mem_unsigned <= s_mem_contral_bus_i[MC_UNS];
      end
    end
  end

  // Load lane extraction and sign/zero extension from the returned word
  always_comb begin
    logic [7:0]  bsel;
    logic [15:0] hsel;
    case (ea[1:0])
      2'd0:    bsel = dmem_rdata[7:0];
      2'd1:    bsel = dmem_rdata[15:8];
      2'd2:    bsel = dmem_rdata[23:16];
      default: bsel = dmem_rdata[31:24];
    endcase
    hsel = ea[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (mem_size)
      2'b00:   load_ext = {{24{bsel[7] & ~mem_unsigned}}, bsel};
      2'b01:   load_ext = {{16{hsel[15] & ~mem_unsigned}}, hsel};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Load data is registered on the ack cycle and held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       load_q <= '0;
    else if (state == BUSY && dmem_ack) load_q <= load_ext;
  end

  // Store lane steering: data replicated, strobes pick the addressed lanes
  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = rt;
    case (mem_size)
      2'b00: begin
        dmem_wdata = {4{rt[7:0]}};
        dmem_wstrb = 4'b0001 << ea[1:0];
      end
      2'b01: begin
        dmem_wdata = {2{rt[15:0]}};
        dmem_wstrb = ea[1] ? 4'b1100 : 4'b0011;
      end
      default: dmem_wstrb = 4'b1111;
    endcase
    if (!mem_write) dmem_wstrb = 4'b0000;
  end

  // Request is purely state-decoded so an async reset drops it immediately.
  assign dmem_req        = (state == BUSY);
  assign dmem_we         = mem_write;
  assign dmem_addr       = {ea[DMEM_AW-1:2], 2'b00};
  assign s_reg_write_bus = wb_q;
  assign mem_result      = (state == DONE && mem_read) ? load_q : ea;
  assign align_err       = align_q;

endmodule
